// File: rtl/fsm_enchimento.sv
// rtl/fsm_enchimento.sv - filling-station slave Moore FSM: valve drive, level handshake, timeout alarm
// Optional fill counter output total_enchidas enabled by `define ENCH_CONTADOR_EN.
module fsm_enchimento #(
  parameter int TIMER_W     = 28,
  parameter int TEMPO_MAX   = 150000000,
  parameter int TEMPO_ESTAB = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_encher,
  input  logic       sensor_nivel,
  input  logic       limpar_erro,
  output logic       valvula_ativa,
  output logic       enchimento_concluido,
  output logic       alarme_enchimento,
  output logic [2:0] estado_dbg
`ifdef ENCH_CONTADOR_EN
  ,
  output logic [15:0] total_enchidas
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENCHENDO   = 3'd1,
    ESTABILIZA = 3'd2,
    CONCLUIDO  = 3'd3,
    ERRO       = 3'd4
  } estado_t;

  localparam logic [TIMER_W-1:0] LIM_ENCH  = TIMER_W'(TEMPO_MAX - 1);
  localparam logic [TIMER_W-1:0] LIM_ESTAB = TIMER_W'(TEMPO_ESTAB - 1);

  estado_t              state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 sync1_q, sync1_d;
  logic                 nivel_s_q, nivel_s_d;

  // Two-flop synchronizer for the asynchronous level switch.
  always_comb begin
    sync1_d   = sensor_nivel;
    nivel_s_d = sync1_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_encher) state_d = nivel_s_q ? ESTABILIZA : ENCHENDO;
      end
      ENCHENDO: begin
        // Level is checked before the timeout so a full bottle never alarms.
        if (!cmd_encher)            state_d = IDLE;
        else if (nivel_s_q)         state_d = ESTABILIZA;
        else if (timer_q == LIM_ENCH) state_d = ERRO;
      end
      ESTABILIZA: begin
        if (!cmd_encher)               state_d = IDLE;
        else if (timer_q == LIM_ESTAB) state_d = CONCLUIDO;
      end
      CONCLUIDO: begin
        if (!cmd_encher) state_d = IDLE;
      end
      ERRO: begin
        if (limpar_erro) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == ENCHENDO || state_q == ESTABILIZA)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sync1_q   <= 1'b0;
      nivel_s_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sync1_q   <= sync1_d;
      nivel_s_q <= nivel_s_d;
    end
  end

  // Outputs come only from the registered state, so reset closes the valve without a clock.
  assign valvula_ativa        = (state_q == ENCHENDO);
  assign enchimento_concluido = (state_q == CONCLUIDO);
  assign alarme_enchimento    = (state_q == ERRO);
  assign estado_dbg           = state_q;

`ifdef ENCH_CONTADOR_EN
  logic [15:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (state_q == ESTABILIZA && state_d == CONCLUIDO)
      contagem_d = contagem_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) contagem_q <= '0;
    else       contagem_q <= contagem_d;
  end

  assign total_enchidas = contagem_q;
`endif

endmodule

// File: tb/tb_fsm_enchimento.sv
// tb/tb_fsm_enchimento.sv - directed table-driven bench for fsm_enchimento
module tb_fsm_enchimento;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_encher;
  logic       sensor_nivel;
  logic       limpar_erro;
  logic       valvula_ativa;
  logic       enchimento_concluido;
  logic       alarme_enchimento;
  logic [2:0] estado_dbg;
`ifdef ENCH_CONTADOR_EN
  logic [15:0] total_enchidas;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsm_enchimento #(.TIMER_W(28), .TEMPO_MAX(20), .TEMPO_ESTAB(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .cmd_encher           (cmd_encher),
    .sensor_nivel         (sensor_nivel),
    .limpar_erro          (limpar_erro),
    .valvula_ativa        (valvula_ativa),
    .enchimento_concluido (enchimento_concluido),
    .alarme_enchimento    (alarme_enchimento),
    .estado_dbg           (estado_dbg)
`ifdef ENCH_CONTADOR_EN
    ,
    .total_enchidas       (total_enchidas)
`endif
  );

  typedef struct {
    logic       cmd;
    logic       sens;
    logic       limpar;
    logic [5:0] exp;   // {valve, ack, alarm, state[2:0]}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] ex(logic v, logic a, logic al, logic [2:0] st);
    return {v, a, al, st};
  endfunction

  function automatic void add(logic c, logic s, logic l, logic [5:0] e);
    vec_t t;
    t.cmd = c; t.sens = s; t.limpar = l; t.exp = e;
    vecs.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [5:0] exp);
    logic [5:0] got;
    got = {valvula_ativa, enchimento_concluido, alarme_enchimento, estado_dbg};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {valve,ack,alarm,state}=%b, expected %b", name, got, exp);
    end
  endtask

  initial begin
    // Row i: inputs applied, then outputs checked just after the next rising edge.
    add(0,0,0, ex(0,0,0,0));
    add(1,0,0, ex(1,0,0,1));   // valve rises one cycle after cmd
    add(1,0,0, ex(1,0,0,1));
    add(1,1,0, ex(1,0,0,1));   // sensor enters synchronizer
    add(1,1,0, ex(1,0,0,1));
    add(1,1,0, ex(0,0,0,2));   // FSM sees level -> ESTABILIZA
    add(1,0,0, ex(0,0,0,2));   // level drop ignored while settling
    add(1,0,0, ex(0,0,0,2));
    add(1,0,0, ex(0,0,0,2));
    add(1,0,0, ex(0,1,0,3));   // ack 4 cycles after entering ESTABILIZA
    add(1,0,0, ex(0,1,0,3));
    add(0,0,0, ex(0,0,0,0));   // ack drops one cycle after cmd low
    add(0,0,0, ex(0,0,0,0));
    add(1,0,0, ex(1,0,0,1));   // abort in ENCHENDO
    add(1,0,0, ex(1,0,0,1));
    add(1,0,0, ex(1,0,0,1));
    add(1,0,0, ex(1,0,0,1));
    add(1,0,0, ex(1,0,0,1));
    add(0,0,0, ex(0,0,0,0));
    add(0,1,0, ex(0,0,0,0));   // pre-full bottle
    add(0,1,0, ex(0,0,0,0));
    add(1,1,0, ex(0,0,0,2));
    add(1,1,0, ex(0,0,0,2));
    add(1,1,0, ex(0,0,0,2));
    add(1,1,0, ex(0,0,0,2));
    add(1,1,0, ex(0,1,0,3));
    add(0,1,0, ex(0,0,0,0));
    add(1,1,0, ex(0,0,0,2));   // abort in ESTABILIZA
    add(0,1,0, ex(0,0,0,0));
    add(0,0,0, ex(0,0,0,0));
    add(0,0,0, ex(0,0,0,0));
    add(0,0,1, ex(0,0,0,0));   // clear outside ERRO does nothing

    reset = 1'b1; cmd_encher = 1'b0; sensor_nivel = 1'b0; limpar_erro = 1'b0;
    tick(); tick();
    check("reset_state", ex(0,0,0,0));
    reset = 1'b0;

    foreach (vecs[i]) begin
      cmd_encher   = vecs[i].cmd;
      sensor_nivel = vecs[i].sens;
      limpar_erro  = vecs[i].limpar;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    limpar_erro = 1'b0;

    // Timeout: valve open exactly 20 cycles, then latched alarm.
    cmd_encher = 1'b1; sensor_nivel = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("timeout_valve%0d", k), ex(1,0,0,1));
    end
    tick();
    check("timeout_erro", ex(0,0,1,4));
    cmd_encher = 1'b0;
    tick(); tick();
    check("erro_hold_cmd0", ex(0,0,1,4));
    cmd_encher = 1'b1;
    tick();
    check("erro_ignores_cmd", ex(0,0,1,4));
    cmd_encher = 1'b0; limpar_erro = 1'b1;
    tick();
    check("erro_clear", ex(0,0,0,0));
    limpar_erro = 1'b0;

    // Level seen on the same cycle the timer reaches TEMPO_MAX-1: level wins.
    cmd_encher = 1'b1;
    for (int k = 1; k <= 18; k++) tick();
    check("simul_enchendo", ex(1,0,0,1));
    sensor_nivel = 1'b1;
    tick(); tick(); tick();
    check("simul_level_wins", ex(0,0,0,2));
    tick(); tick(); tick(); tick();
    check("simul_concluido", ex(0,1,0,3));
    cmd_encher = 1'b0; sensor_nivel = 1'b0;
    tick();
    check("simul_idle", ex(0,0,0,0));

`ifdef ENCH_CONTADOR_EN
    n_cmp++;
    if (total_enchidas !== 16'd3) begin
      n_fail++;
      $display("FAIL fill_count: got %0d, expected 3", total_enchidas);
    end
`endif

    // Asynchronous reset mid-fill closes the valve with no clock edge.
    tick(); tick();
    cmd_encher = 1'b1;
    tick(); tick(); tick();
    check("pre_async_reset", ex(1,0,0,1));
    #3 reset = 1'b1;
    #1 check("async_reset", ex(0,0,0,0));
    cmd_encher = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", ex(0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_enchimento.md
Name: fsm_enchimento

Overview:
Slave Moore FSM for the filling station, directly downstream of the master sequencer. It consumes the master's level-held fill command and drives the fill valve. It monitors the bottle level sensor and returns a completion flag using a 4-phase handshake. A fill-timeout watchdog latches an alarm when the level is not reached in time.

Parameters:
TIMER_W, 28, width of the internal cycle timer.
TEMPO_MAX, 150000000, max valve-open cycles before timeout (3.0 s @ 50 MHz); must be ≥2 and fit in TIMER_W.
TEMPO_ESTAB, 12500000, settle cycles after level reached, valve closed (0.25 s); must be ≥1.

Ports:
clk  input  1  50 MHz clock
reset  input  1  asynchronous, active-high reset
cmd_encher  input  1  fill request from master; held high until completion is seen
sensor_nivel  input  1  level-full switch; asynchronous, synchronized internally
limpar_erro  input  1  synchronous clear of the timeout alarm (pulse)
valvula_ativa  output  1  fill valve / LED drive
enchimento_concluido  output  1  completion acknowledge to master
alarme_enchimento  output  1  latched fill-timeout alarm
estado_dbg  output  3  current state code, for debug LEDs

Behaviour:
- Reset: state IDLE; timer 0; sync flops 0; all outputs 0.
- sensor_nivel passes through a 2-flop synchronizer (nivel_s); 2-cycle latency before the FSM sees a change.
- All outputs are decoded from the registered state only (Moore): valvula_ativa=ENCHENDO; enchimento_concluido=CONCLUIDO; alarme_enchimento=ERRO.
- State codes: IDLE=0, ENCHENDO=1, ESTABILIZA=2, CONCLUIDO=3, ERRO=4; 5–7 go to IDLE next cycle.
- Timer clears on every state change; it increments each cycle in ENCHENDO and ESTABILIZA.
- IDLE:
  - cmd_encher=1 & nivel_s=1 -> ESTABILIZA (bottle already full; valve never opens).
  - cmd_encher=1 & nivel_s=0 -> ENCHENDO. The valve rises the cycle after cmd is sampled.
- ENCHENDO, priority order:
  - cmd_encher=0 -> IDLE (abort; no ack).
  - nivel_s=1 -> ESTABILIZA.
  - timer==TEMPO_MAX-1 -> ERRO.
  - Level wins over timeout in the same cycle. Valve open time is exactly TEMPO_MAX cycles at timeout.
- ESTABILIZA, priority order:
  - cmd_encher=0 -> IDLE.
  - timer==TEMPO_ESTAB-1 -> CONCLUIDO.
  - nivel_s dropping here is ignored.
- CONCLUIDO: ack held high while cmd_encher=1; cmd_encher=0 -> IDLE. A new fill needs a cmd low→high edge, because ack must drop first.
- ERRO: valve closed, alarm high, ack never asserted; exit to IDLE only on limpar_erro=1. The cmd level is ignored in ERRO.
- limpar_erro has no effect outside ERRO.
- Async reset mid-fill closes the valve immediately, with no clock required.

Optional Feature:
ENCH_CONTADOR_EN:
- When defined, adds output total_enchidas[15:0], reset 0.
- The counter increments by 1 on every ENCHENDO/IDLE→ESTABILIZA→CONCLUIDO entry into CONCLUIDO and wraps 0xFFFF→0.
- Aborted and timed-out fills are not counted.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
(Sim with TEMPO_MAX=20, TEMPO_ESTAB=4.)
- Normal fill: reset, cmd_encher=1 at t0, sensor_nivel=1 at t0+10 -> valve 1 from t0+1; valve 0 two to three cycles after the sensor rises; ack=1 exactly 4 cycles after entering ESTABILIZA; ack drops 1 cycle after cmd_encher=0.
- Timeout: cmd_encher=1, sensor held 0 -> valve high exactly 20 cycles, then alarme=1, valve=0, ack=0. cmd_encher=0 keeps the alarm set. limpar_erro pulse -> IDLE, alarm 0.
- Pre-full bottle: sensor_nivel=1 held, then cmd_encher=1 -> valve never asserts; ack after 4 settle cycles.
- Abort: cmd_encher drops in ENCHENDO at cycle 5, and separately in ESTABILIZA -> IDLE next cycle, valve 0, ack never asserts.
- Simultaneous: sensor synchronized high on the same cycle timer reaches 19 -> ESTABILIZA, no alarm. Async reset asserted mid-ENCHENDO -> valve 0 immediately, all outputs 0.
- With ENCH_CONTADOR_EN: 3 normal fills + 1 timeout + 1 abort -> total_enchidas=3. Preload/force 0xFFFF then 1 fill -> 0.
